counter_cmd_conditioner: RTL
============================

# counter_cmd_conditioner

Upstream command stage for the 4-bit up/down counter. Takes three raw, asynchronous push-button inputs and a 4-bit switch bank, then synchronizes and debounces them. It emits clean, single-cycle, mutually exclusive `load`/`up`/`down` pulses plus a held `data_in` value that wire directly to the counter's same-named inputs.

## Interface
- `DEBOUNCE_CYCLES`, default 4: consecutive stable synchronized cycles required to accept a level change; legal range ≥1.
- `REPEAT_DELAY`, default 16: cycles a held up/down button waits before auto-repeat begins. Used only with `CMD_AUTOREPEAT_EN`.
- `REPEAT_PERIOD`, default 8: cycles between auto-repeat pulses; ≥1. Used only with `CMD_AUTOREPEAT_EN`.
- `clk` in 1: single clock domain.
- `reset` in 1: asynchronous, active-high. Clears all state.
- `btn_load_raw` in 1: raw load button, asynchronous, active-high.
- `btn_up_raw` in 1: raw up button, asynchronous, active-high.
- `btn_down_raw` in 1: raw down button, asynchronous, active-high.
- `sw_data` in 4: raw switch bank, asynchronous.
- `load` out 1: one-cycle load pulse, registered.
- `up` out 1: one-cycle increment pulse, registered.
- `down` out 1: one-cycle decrement pulse, registered.
- `data_in` out 4: load value, registered. Held until the next `load`.

## Operation
- **Synchronizer.** Each button and each `sw_data` bit passes through a 2-flop synchronizer, giving `*_sync`.
- **Debounce FSM.** Each button has its own FSM with a stable level and a counter of width clog2(DEBOUNCE_CYCLES+1).
  - IDLE (stable 0): `sync`=1 → PRESS_PEND, counter=1.
  - PRESS_PEND: `sync`=0 → IDLE, counter cleared. Counter reaching DEBOUNCE_CYCLES → HELD with stable 1, and a one-cycle press event is raised.
  - HELD: `sync`=0 → RELEASE_PEND, counter=1.
  - RELEASE_PEND: `sync`=1 → HELD. Counter reaching DEBOUNCE_CYCLES → IDLE. A release produces no event.
  - When DEBOUNCE_CYCLES=1, the PEND state lasts exactly one cycle.
- **Arbitration.** When several events occur in the same cycle, load wins over up, and up wins over down. Losing events are dropped, not queued. At most one of `load`/`up`/`down` is high in any cycle.
- **Load value.** On the cycle `load` is registered high, `data_in` registers the synchronized `sw_data`. `data_in` is unchanged on any other cycle.
- **Held buttons.** A button held across another button's press does not re-fire. Only a new IDLE→HELD transition generates an event (auto-repeat excepted).

## Timing
- **Reset values.** `load`=`up`=`down`=0, `data_in`=4'h0. Synchronizers are 0, all FSMs are IDLE, all counters are 0.
- **Press latency.** A raw button first sampled high at edge k (and held) gives `sync`=1 after edge k+1 and stable=1 after edge k+1+DEBOUNCE_CYCLES. The output pulse is high for exactly one cycle following edge k+2+DEBOUNCE_CYCLES.
- **Glitches.** A raw pulse shorter than DEBOUNCE_CYCLES synchronized cycles produces no output.
- **Switch capture.** `sw_data` must be stable for ≥2 cycles before the `load` pulse edge to be captured.
- **Reset mid-press.** If a button is still high when reset deasserts, its FSM restarts from IDLE. The button is re-debounced and produces a press event with the normal latency.
- **Minimum press spacing.** Back-to-back presses on one button require ≥2·DEBOUNCE_CYCLES cycles between events (release debounce plus press debounce).

## Configuration
- **`CMD_AUTOREPEAT_EN` defined.**
  - Once a button is in HELD, its counter keeps counting.
  - The first repeat event fires REPEAT_DELAY cycles after the original press event. Further repeats fire every REPEAT_PERIOD cycles until the FSM leaves HELD.
  - Repeat events apply to up and down only. Load never repeats.
  - Repeat events go through the normal arbitration.
- **`CMD_AUTOREPEAT_EN` undefined.**
  - Exactly one event per press.
  - The repeat counter and the REPEAT_* parameters are unused and synthesize away.

## Structure
- **Package `counter_cmd_pkg`** holds:
  - `debounce_state_t`, an enum of IDLE, PRESS_PEND, HELD, RELEASE_PEND.
  - The arbitration priority constants.
  - The 4-bit data width constant, shared with the counter.
- **Sub-module `btn_debounce`** contains the synchronizer, debounce FSM and optional repeat timer. It outputs a press event and the stable level. The top instantiates it three times.
- **Top level** holds the `sw_data` synchronizer, the arbiter and the output registers.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4.
- **Reset.** Assert `reset` mid-run → all outputs 0 and `data_in`=0 immediately, without waiting for a clock edge.
- **Clean press.** Clean `btn_up_raw` press, first sampled high at edge 10 and held 50 cycles → exactly one `up` pulse, high after edge 16, with no `load`/`down`.
- **Glitch.** A 3-cycle `btn_down_raw` glitch → no `down` pulse. A 4-cycle-stable bounce-then-hold → exactly one `down` pulse.
- **Load capture.** `sw_data`=4'hA, then a `btn_load_raw` press → a one-cycle `load` pulse, with `data_in`=4'hA on that cycle. Then `sw_data`=4'h3 with no press → `data_in` stays 4'hA.
- **Simultaneous press.** Raw load and up rise on the same edge → only `load` pulses, and no `up` pulse follows while up remains held.
- **Auto-repeat.** With `CMD_AUTOREPEAT_EN`, REPEAT_DELAY=16 and REPEAT_PERIOD=8, hold up for 60 cycles after its press event → pulses at offsets 0, 16, 24, 32, 40, 48, 56. Without the macro → a single pulse.

Source files
------------

// File: rtl/counter_cmd_pkg.sv
// rtl/counter_cmd_pkg.sv - shared types, constants and arbiter for the counter command stage
// Contents: debounce_state_t, cmd_t, DATA_W, arbitration priorities, arbitrate().
package counter_cmd_pkg;

  // Width of the switch bank and of the counter's load value.
  localparam int DATA_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    PRESS_PEND,
    HELD,
    RELEASE_PEND
  } debounce_state_t;

  typedef enum logic [1:0] {
    CMD_NONE,
    CMD_LOAD,
    CMD_UP,
    CMD_DOWN
  } cmd_t;

  // Higher value wins when several events land in the same cycle.
  localparam int PRIO_LOAD = 2;
  localparam int PRIO_UP   = 1;
  localparam int PRIO_DOWN = 0;

  // Picks the single highest-priority event; losers are simply dropped.
  function automatic cmd_t arbitrate(input logic load_evt, input logic up_evt,
                                     input logic down_evt);
    cmd_t pick;
    int   pick_prio;
    pick      = CMD_NONE;
    pick_prio = -1;
    if (down_evt && (PRIO_DOWN > pick_prio)) begin
      pick      = CMD_DOWN;
      pick_prio = PRIO_DOWN;
    end
    if (up_evt && (PRIO_UP > pick_prio)) begin
      pick      = CMD_UP;
      pick_prio = PRIO_UP;
    end
    if (load_evt && (PRIO_LOAD > pick_prio)) begin
      pick = CMD_LOAD;
    end
    return pick;
  endfunction

endpackage

// File: rtl/counter_cmd_conditioner_btn_debounce.sv
// rtl/counter_cmd_conditioner_btn_debounce.sv - per-button synchronizer, debounce FSM and optional repeat timer
// Ports: clk, reset (async, active-high), raw (asynchronous button),
//        press (one-cycle registered press/repeat event), level (debounced stable level).
// Optional feature: CMD_AUTOREPEAT_EN enables the repeat timer (only when REPEAT_EN=1).
module btn_debounce
  import counter_cmd_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int REPEAT_DELAY    = 16,
  parameter int REPEAT_PERIOD   = 8,
  parameter bit REPEAT_EN       = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic press,
  output logic level
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  // Counter value on the last pending cycle: the next stable sample completes the debounce.
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]      sync_ff;
  logic            sync;
  debounce_state_t state, state_next;
  logic [CW-1:0]   cnt, cnt_next;
  logic            press_next;
  logic            rpt_fire;

  assign sync = sync_ff[1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) sync_ff <= 2'b00;
    else       sync_ff <= {sync_ff[0], raw};
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    press_next = 1'b0;
    case (state)
      IDLE: begin
        if (sync) begin
          state_next = PRESS_PEND;
          cnt_next   = CW'(1);
        end
      end
      PRESS_PEND: begin
        if (!sync) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else if (cnt >= CNT_LAST) begin
          state_next = HELD;
          cnt_next   = '0;
          press_next = 1'b1;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      HELD: begin
        if (!sync) begin
          state_next = RELEASE_PEND;
          cnt_next   = CW'(1);
        end
      end
      RELEASE_PEND: begin
        if (sync) begin
          state_next = HELD;
          cnt_next   = '0;
        end else if (cnt >= CNT_LAST) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

`ifdef CMD_AUTOREPEAT_EN
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW   = $clog2(RMAX + 1);

  logic [RW-1:0] rpt_cnt;
  logic [RW-1:0] rpt_last;
  logic          rpt_phase;  // 0: waiting for first repeat, 1: periodic repeats

  assign rpt_last = rpt_phase ? RW'(REPEAT_PERIOD - 1) : RW'(REPEAT_DELAY - 1);
  assign rpt_fire = REPEAT_EN && (state == HELD) && sync && (rpt_cnt == rpt_last);

  // Timer restarts whenever the FSM is not staying in HELD, so every entry
  // into HELD begins a fresh REPEAT_DELAY wait.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rpt_cnt   <= '0;
      rpt_phase <= 1'b0;
    end else if ((state != HELD) || !sync) begin
      rpt_cnt   <= '0;
      rpt_phase <= 1'b0;
    end else if (rpt_fire) begin
      rpt_cnt   <= '0;
      rpt_phase <= 1'b1;
    end else begin
      rpt_cnt <= rpt_cnt + 1'b1;
    end
  end
`else
  localparam int unused_repeat_cfg = REPEAT_DELAY + REPEAT_PERIOD + int'(REPEAT_EN);
  assign rpt_fire = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      press <= press_next | rpt_fire;
    end
  end

  assign level = (state == HELD) || (state == RELEASE_PEND);

endmodule

// File: rtl/counter_cmd_conditioner.sv
// rtl/counter_cmd_conditioner.sv - button/switch conditioner producing load/up/down pulses for the counter
// Ports: clk, reset (async, active-high), btn_load_raw/btn_up_raw/btn_down_raw (raw buttons),
//        sw_data[3:0] (raw switches), load/up/down (one-cycle exclusive pulses),
//        data_in[3:0] (value captured on load, held otherwise).
// Optional feature: CMD_AUTOREPEAT_EN (auto-repeat of held up/down buttons).
module counter_cmd_conditioner
  import counter_cmd_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int REPEAT_DELAY    = 16,
  parameter int REPEAT_PERIOD   = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              btn_load_raw,
  input  logic              btn_up_raw,
  input  logic              btn_down_raw,
  input  logic [DATA_W-1:0] sw_data,
  output logic              load,
  output logic              up,
  output logic              down,
  output logic [DATA_W-1:0] data_in
);

  logic              evt_load, evt_up, evt_down;
  logic              lvl_load, lvl_up, lvl_down;
  logic [2:0]        unused_levels;
  logic [DATA_W-1:0] sw_meta, sw_sync;
  cmd_t              cmd;

  // Load never auto-repeats.
  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .REPEAT_DELAY(REPEAT_DELAY),
    .REPEAT_PERIOD(REPEAT_PERIOD), .REPEAT_EN(1'b0)
  ) u_db_load (
    .clk(clk), .reset(reset), .raw(btn_load_raw), .press(evt_load), .level(lvl_load)
  );

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .REPEAT_DELAY(REPEAT_DELAY),
    .REPEAT_PERIOD(REPEAT_PERIOD), .REPEAT_EN(1'b1)
  ) u_db_up (
    .clk(clk), .reset(reset), .raw(btn_up_raw), .press(evt_up), .level(lvl_up)
  );

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .REPEAT_DELAY(REPEAT_DELAY),
    .REPEAT_PERIOD(REPEAT_PERIOD), .REPEAT_EN(1'b1)
  ) u_db_down (
    .clk(clk), .reset(reset), .raw(btn_down_raw), .press(evt_down), .level(lvl_down)
  );

  // Stable levels are available for status use; the command path only needs events.
  assign unused_levels = {lvl_load, lvl_up, lvl_down};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sw_meta <= '0;
      sw_sync <= '0;
    end else begin
      sw_meta <= sw_data;
      sw_sync <= sw_meta;
    end
  end

  assign cmd = arbitrate(evt_load, evt_up, evt_down);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      load    <= 1'b0;
      up      <= 1'b0;
      down    <= 1'b0;
      data_in <= '0;
    end else begin
      load <= (cmd == CMD_LOAD);
      up   <= (cmd == CMD_UP);
      down <= (cmd == CMD_DOWN);
      if (cmd == CMD_LOAD) data_in <= sw_sync;
    end
  end

endmodule
